// File: rtl/sfm_tcdm_lane_sync.sv
// Lane synchroniser between a wide HCI master port and MP independent 32-bit TCDM ports.
// Tracks per-lane grants, bounds outstanding wide reads and re-aligns per-lane read data.
module sfm_tcdm_lane_sync #(
  parameter int unsigned MP        = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wide_req_i,
  output logic              wide_gnt_o,
  input  logic [31:0]       wide_add_i,
  input  logic              wide_wen_i,
  input  logic [MP*4-1:0]   wide_be_i,
  input  logic [MP*32-1:0]  wide_data_i,
  output logic [MP*32-1:0]  wide_r_data_o,
  output logic              wide_r_valid_o,
  input  logic              wide_r_ready_i,
  output logic [MP-1:0]     tcdm_req_o,
  input  logic [MP-1:0]     tcdm_gnt_i,
  output logic [MP*32-1:0]  tcdm_add_o,
  output logic [MP-1:0]     tcdm_wen_o,
  output logic [MP*4-1:0]   tcdm_be_o,
  output logic [MP*32-1:0]  tcdm_data_o,
  input  logic [MP*32-1:0]  tcdm_r_data_i,
  input  logic [MP-1:0]     tcdm_r_valid_i,
  output logic [MP-1:0]     tcdm_r_ready_o
);

  localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned OCC_W = $clog2(MAX_OUTST + 1);

  logic [MP-1:0]    gnt_q;
  logic [MP-1:0]    gnt_eff;
  logic [MP-1:0]    lane_hs;
  logic [MP-1:0]    lane_done;
  logic [CNT_W-1:0] outst_q;
  logic             credit_ok;
  logic             wide_gnt;
  logic             pop;
  logic [MP-1:0]    empty;
  logic [MP-1:0]    full;
  logic [MP-1:0]    push;

  logic [31:0]      mem_q  [MP][MAX_OUTST];
  logic [PTR_W-1:0] wptr_q [MP];
  logic [PTR_W-1:0] rptr_q [MP];
  logic [OCC_W-1:0] occ_q  [MP];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Per-lane fan-out of the wide request fields
  always_comb begin
    tcdm_add_o  = '0;
    tcdm_wen_o  = {MP{wide_wen_i}};
    tcdm_be_o   = wide_be_i;
    tcdm_data_o = wide_data_i;
    for (int unsigned i = 0; i < MP; i++) begin
      tcdm_add_o[32*i +: 32] = wide_add_i + 32'(4 * i);
    end
  end

  // Request gating, grant combining and response alignment
  always_comb begin
    credit_ok  = !wide_wen_i || (outst_q < CNT_W'(MAX_OUTST));
    gnt_eff    = rst_i ? '0 : gnt_q;
    tcdm_req_o = {MP{wide_req_i & credit_ok}} & ~gnt_eff;
    lane_hs    = tcdm_req_o & tcdm_gnt_i;
    lane_done  = gnt_eff | lane_hs;
    wide_gnt   = wide_req_i & credit_ok & (&lane_done) & ~rst_i;
    empty      = '0;
    full       = '0;
    for (int unsigned i = 0; i < MP; i++) begin
      empty[i] = (occ_q[i] == '0);
      full[i]  = (occ_q[i] == OCC_W'(MAX_OUTST));
    end
    wide_r_valid_o = ~rst_i & (&(~empty));
    pop            = wide_r_valid_o & wide_r_ready_i;
    push           = tcdm_r_valid_i & ~full;
    tcdm_r_ready_o = rst_i ? '1 : ~full;
    wide_r_data_o  = '0;
    for (int unsigned i = 0; i < MP; i++) begin
      wide_r_data_o[32*i +: 32] = wide_r_valid_o ? mem_q[i][rptr_q[i]] : 32'h0;
    end
  end

  assign wide_gnt_o = wide_gnt;

  // Granted-lane mask and outstanding wide-read counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_q   <= '0;
      outst_q <= '0;
    end else begin
      gnt_q   <= wide_gnt ? '0 : (gnt_q | lane_hs);
      outst_q <= outst_q + CNT_W'(wide_gnt & wide_wen_i) - CNT_W'(pop);
    end
  end

  // Lane FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < MP; i++) begin
      if (rst_i) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        occ_q[i]  <= '0;
      end else begin
        if (push[i]) wptr_q[i] <= ptr_inc(wptr_q[i]);
        if (pop)     rptr_q[i] <= ptr_inc(rptr_q[i]);
        case ({push[i], pop})
          2'b10:   occ_q[i] <= occ_q[i] + OCC_W'(1);
          2'b01:   occ_q[i] <= occ_q[i] - OCC_W'(1);
          default: occ_q[i] <= occ_q[i];
        endcase
      end
    end
  end

  // Lane FIFO storage (contents are don't-care while the pointers say empty)
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < MP; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= tcdm_r_data_i[32*i +: 32];
    end
  end

  // Protocol and credit invariants
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (outst_q <= CNT_W'(MAX_OUTST));
      assert (!(pop && (outst_q == '0)));
      assert ((tcdm_r_valid_i & full) == '0);
      assert (!((|gnt_q) && !wide_req_i));
    end
  end

endmodule

// File: tb/tb_sfm_tcdm_lane_sync.sv
// Scoreboard bench for sfm_tcdm_lane_sync: directed scenarios plus randomized traffic.
module tb_sfm_tcdm_lane_sync;

  localparam int unsigned MP = 4;
  localparam int unsigned NW = 64;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             wide_req_i;
  logic             wide_gnt_o;
  logic [31:0]      wide_add_i;
  logic             wide_wen_i;
  logic [MP*4-1:0]  wide_be_i;
  logic [MP*32-1:0] wide_data_i;
  logic [MP*32-1:0] wide_r_data_o;
  logic             wide_r_valid_o;
  logic             wide_r_ready_i;
  logic [MP-1:0]    tcdm_req_o;
  logic [MP-1:0]    tcdm_gnt_i;
  logic [MP*32-1:0] tcdm_add_o;
  logic [MP-1:0]    tcdm_wen_o;
  logic [MP*4-1:0]  tcdm_be_o;
  logic [MP*32-1:0] tcdm_data_o;
  logic [MP*32-1:0] tcdm_r_data_i;
  logic [MP-1:0]    tcdm_r_valid_i;
  logic [MP-1:0]    tcdm_r_ready_o;

  logic [MP-1:0] gnt_rand, gnt_force;
  logic          gnt_force_en;
  logic          ready_rand, ready_force, ready_force_en;
  assign tcdm_gnt_i     = gnt_force_en ? gnt_force : gnt_rand;
  assign wide_r_ready_i = ready_force_en ? ready_force : ready_rand;

  always #5 clk_i = ~clk_i;

  sfm_tcdm_lane_sync #(.MP(MP), .MAX_OUTST(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wide_req_i(wide_req_i), .wide_gnt_o(wide_gnt_o), .wide_add_i(wide_add_i),
    .wide_wen_i(wide_wen_i), .wide_be_i(wide_be_i), .wide_data_i(wide_data_i),
    .wide_r_data_o(wide_r_data_o), .wide_r_valid_o(wide_r_valid_o), .wide_r_ready_i(wide_r_ready_i),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_ready_o(tcdm_r_ready_o)
  );

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q[$];
  logic [31:0]  ref_mem [NW];
  logic [31:0]  tcdm_mem[NW];
  int           lat[MP];
  logic [31:0]  rsp_d[MP][$];
  int           rsp_due[MP][$];
  int           cyc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  function automatic logic [31:0] init_val(input int k);
    return (k < 4) ? 32'((k + 1) * 32'h11) : (32'hC0DE0000 | 32'(k));
  endfunction

  function automatic int widx(input logic [31:0] add);
    return int'((add >> 2) % NW);
  endfunction

  // TCDM lane model: memory, per-lane in-order responses with programmable latency
  initial begin
    for (int k = 0; k < NW; k++) tcdm_mem[k] = init_val(k);
    cyc = 0; gnt_rand = '0; ready_rand = 1'b0;
    tcdm_r_valid_i = '0; tcdm_r_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        for (int i = 0; i < MP; i++) begin
          rsp_d[i].delete(); rsp_due[i].delete();
        end
      end else begin
        for (int i = 0; i < MP; i++) begin
          if (tcdm_r_valid_i[i] && tcdm_r_ready_o[i]) begin
            void'(rsp_d[i].pop_front()); void'(rsp_due[i].pop_front());
          end
          if (tcdm_req_o[i] && tcdm_gnt_i[i]) begin
            int idx;
            idx = widx(tcdm_add_o[32*i +: 32]);
            if (tcdm_wen_o[i]) begin
              rsp_d[i].push_back(tcdm_mem[idx]);
              rsp_due[i].push_back(cyc + 1 + lat[i]);
            end else begin
              for (int b = 0; b < 4; b++)
                if (tcdm_be_o[4*i + b]) tcdm_mem[idx][8*b +: 8] = tcdm_data_o[32*i + 8*b +: 8];
            end
          end
        end
      end
      @(posedge clk_i); #1;
      cyc++;
      gnt_rand   = MP'($urandom);
      ready_rand = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < MP; i++) begin
        if (rsp_d[i].size() != 0 && rsp_due[i][0] <= cyc) begin
          tcdm_r_valid_i[i] = 1'b1;
          tcdm_r_data_i[32*i +: 32] = rsp_d[i][0];
        end else begin
          tcdm_r_valid_i[i] = 1'b0;
          tcdm_r_data_i[32*i +: 32] = $urandom;
        end
      end
    end
  end

  // Monitor: fan-out checks and scoreboard pop on each wide response handshake
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (wide_req_i) begin
          logic [127:0] ea;
          for (int i = 0; i < MP; i++) ea[32*i +: 32] = wide_add_i + 32'(4 * i);
          chk("fan_add", tcdm_add_o, ea);
          chk("fan_wen", tcdm_wen_o, {MP{wide_wen_i}});
          chk("fan_be", tcdm_be_o, wide_be_i);
          chk("fan_data", tcdm_data_o, wide_data_i);
        end
        if (wide_r_valid_o && wide_r_ready_i) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rsp_unexpected actual=%h required=no response", wide_r_data_o);
          end else begin
            chk("rsp_data", wide_r_data_o, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic set_req(input logic wen, input logic [31:0] add, input logic [15:0] be,
                         input logic [127:0] data);
    wide_req_i = 1'b1; wide_wen_i = wen; wide_add_i = add; wide_be_i = be; wide_data_i = data;
  endtask

  // Reference effect of an accepted wide transaction, from the wide fields alone
  task automatic record();
    logic [127:0] e;
    if (wide_wen_i) begin
      for (int i = 0; i < MP; i++) e[32*i +: 32] = ref_mem[widx(wide_add_i + 32'(4 * i))];
      exp_q.push_back(e);
    end else begin
      for (int i = 0; i < MP; i++)
        for (int b = 0; b < 4; b++)
          if (wide_be_i[4*i + b])
            ref_mem[widx(wide_add_i + 32'(4 * i))][8*b +: 8] = wide_data_i[32*i + 8*b +: 8];
    end
  endtask

  task automatic issue(input logic wen, input logic [31:0] add, input logic [15:0] be,
                       input logic [127:0] data);
    int n = 0;
    set_req(wen, add, be, data);
    forever begin
      @(negedge clk_i);
      if (wide_gnt_o) break;
      n++;
      if (n > 300) begin fail("gnt_timeout"); break; end
      step();
    end
    if (wide_gnt_o) record();
    step();
    wide_req_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk_i); n++;
    end
    if (exp_q.size() != 0) fail("drain_timeout");
    step();
  endtask

  initial begin
    logic [MP-1:0] gp[5], er[5];
    logic          ew[5];
    int            pulses;
    for (int k = 0; k < NW; k++) ref_mem[k] = init_val(k);
    for (int i = 0; i < MP; i++) lat[i] = 0;
    rst_i = 1'b1; wide_req_i = 1'b0; wide_wen_i = 1'b1; wide_add_i = 32'h1000;
    wide_be_i = '1; wide_data_i = '0;
    gnt_force_en = 1'b1; gnt_force = '0; ready_force_en = 1'b1; ready_force = 1'b1;

    // Reset values
    @(negedge clk_i);
    chk("rst_gnt", wide_gnt_o, 0);
    chk("rst_valid", wide_r_valid_o, 0);
    chk("rst_rready", tcdm_r_ready_o, 4'hF);
    chk("rst_rdata", wide_r_data_o, 0);
    step();
    wide_req_i = 1'b1; gnt_force = 4'hF;
    @(negedge clk_i);
    chk("rst_req", tcdm_req_o, 4'hF);
    chk("rst_gnt_req", wide_gnt_o, 0);
    step();
    rst_i = 1'b0; wide_req_i = 1'b0;
    step();

    // All lanes grant together
    set_req(1'b1, 32'h1000, 16'hFFFF, '0);
    @(negedge clk_i);
    chk("A_gnt", wide_gnt_o, 1);
    chk("A_add", tcdm_add_o, 128'h0000100C_00001008_00001004_00001000);
    if (wide_gnt_o) record();
    step(); wide_req_i = 1'b0;
    @(negedge clk_i);
    chk("A_valid_early", wide_r_valid_o, 0);
    step();
    @(negedge clk_i);
    chk("A_valid", wide_r_valid_o, 1);
    chk("A_data", wide_r_data_o, 128'h00000044_00000033_00000022_00000011);
    drain();

    // Staggered grants
    gp = '{4'b0010, 4'b0000, 4'b0101, 4'b0000, 4'b1000};
    er = '{4'b1111, 4'b1101, 4'b1101, 4'b1000, 4'b1000};
    ew = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    pulses = 0;
    for (int i = 0; i < MP; i++) lat[i] = i;
    set_req(1'b1, 32'h1040, 16'hFFFF, '0);
    for (int c = 0; c < 5; c++) begin
      gnt_force = gp[c];
      @(negedge clk_i);
      chk($sformatf("B_req_c%0d", c), tcdm_req_o, er[c]);
      chk($sformatf("B_gnt_c%0d", c), wide_gnt_o, ew[c]);
      if (wide_gnt_o) begin pulses++; record(); end
      step();
    end
    wide_req_i = 1'b0; gnt_force = 4'hF;
    chk("B_pulses", pulses, 1);
    drain();

    // Staggered read valid: lane 3 three cycles late
    for (int i = 0; i < MP; i++) lat[i] = (i == 3) ? 3 : 0;
    set_req(1'b1, 32'h1080, 16'hFFFF, '0);
    @(negedge clk_i);
    chk("C_gnt", wide_gnt_o, 1);
    if (wide_gnt_o) record();
    step(); wide_req_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      chk($sformatf("C_valid_low%0d", k), wide_r_valid_o, 0);
      step();
    end
    @(negedge clk_i);
    chk("C_valid_high", wide_r_valid_o, 1);
    drain();

    // Credit limit with consumer stalled
    for (int i = 0; i < MP; i++) lat[i] = 0;
    ready_force = 1'b0;
    for (int r = 0; r < 2; r++) begin
      set_req(1'b1, 32'h10C0 + 32'(16 * r), 16'hFFFF, '0);
      @(negedge clk_i);
      chk($sformatf("D_gnt%0d", r), wide_gnt_o, 1);
      if (wide_gnt_o) record();
      step();
    end
    set_req(1'b1, 32'h10E0, 16'hFFFF, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("D_req_blocked", tcdm_req_o, 0);
      chk("D_gnt_blocked", wide_gnt_o, 0);
      chk("D_hold_valid", wide_r_valid_o, 1);
      if (exp_q.size() != 0) chk("D_hold_data", wide_r_data_o, exp_q[0]);
      step();
    end
    ready_force = 1'b1;
    @(negedge clk_i);
    chk("D_gnt_at_pop", wide_gnt_o, 0);
    step(); ready_force = 1'b0;
    @(negedge clk_i);
    chk("D_req_after_pop", tcdm_req_o, 4'hF);
    chk("D_gnt_after_pop", wide_gnt_o, 1);
    if (wide_gnt_o) record();
    step(); wide_req_i = 1'b0; ready_force = 1'b1;
    drain();

    // Write to lane 1 only
    set_req(1'b0, 32'h1010, 16'h00F0, {$urandom, $urandom, $urandom, $urandom});
    @(negedge clk_i);
    chk("E_be", tcdm_be_o, 16'h00F0);
    chk("E_wen", tcdm_wen_o, 4'h0);
    chk("E_gnt", wide_gnt_o, 1);
    if (wide_gnt_o) record();
    step(); wide_req_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("E_no_rsp", wide_r_valid_o, 0);
      step();
    end
    chk("E_outst", dut.outst_q, 0);
    issue(1'b1, 32'h1010, 16'hFFFF, '0);
    drain();

    // Reset in the middle of a partially granted read
    lat = '{0, 5, 5, 5};
    set_req(1'b1, 32'h1020, 16'hFFFF, '0);
    gnt_force = 4'b0001;
    @(negedge clk_i);
    chk("F_gnt_c0", wide_gnt_o, 0);
    step(); gnt_force = 4'b0010;
    @(negedge clk_i);
    chk("F_gnt_c1", wide_gnt_o, 0);
    step(); gnt_force = 4'b0000; rst_i = 1'b1; wide_req_i = 1'b0;
    @(negedge clk_i);
    chk("F_rst_gnt", wide_gnt_o, 0);
    chk("F_rst_rready", tcdm_r_ready_o, 4'hF);
    step(); rst_i = 1'b0; gnt_force = 4'hF;
    @(negedge clk_i);
    chk("F_gnt_q", dut.gnt_q, 0);
    chk("F_outst", dut.outst_q, 0);
    chk("F_valid", wide_r_valid_o, 0);
    step();
    for (int i = 0; i < MP; i++) lat[i] = 0;
    issue(1'b1, 32'h1020, 16'hFFFF, '0);
    drain();

    // Randomized traffic
    gnt_force_en = 1'b0; ready_force_en = 1'b0;
    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < MP; i++) lat[i] = $urandom_range(0, 3);
      issue($urandom_range(0, 3) != 0, 32'h1000 + 32'(4 * $urandom_range(0, NW - 1)),
            16'($urandom), {$urandom, $urandom, $urandom, $urandom});
      repeat ($urandom_range(0, 2)) step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
